// File: rtl/sipo_frame_ctrl.sv
// Framed serial receiver: start bit, WIDTH data bits (MSB first), held parallel output with valid/ready.
// Define SIPO_FRAME_PARITY_EN to add a trailing even-parity bit and drive parity_err.
module sipo_frame_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, PAR, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sr;
  logic [CNT_W-1:0] cnt;
  logic             start, shift_en, xfer, out_free;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (en && in) state_nxt = SHIFT;
      SHIFT: begin
        if (en && (cnt == LAST)) begin
`ifdef SIPO_FRAME_PARITY_EN
          state_nxt = PAR;
`else
          state_nxt = DONE;
`endif
        end
      end
      PAR:   if (en) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    start    = (state == IDLE) && en && in;
    shift_en = (state == SHIFT) && en;
    xfer     = (state == DONE);
    out_free = !q_valid || q_ready;
  end

  // Shift path: counter restarts on every accepted start bit
  always_ff @(posedge clk) begin
    if (rst) begin
      sr  <= '0;
      cnt <= '0;
    end else if (start) begin
      cnt <= '0;
    end else if (shift_en) begin
      sr  <= {sr[WIDTH-2:0], in};
      cnt <= cnt + 1'b1;
    end
  end

  // Output register: DONE loads when free, otherwise the word is dropped and overrun pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      q       <= '0;
      q_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (xfer) begin
        if (out_free) begin
          q       <= sr;
          q_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (q_valid && q_ready) begin
        q_valid <= 1'b0;
      end
    end
  end

`ifdef SIPO_FRAME_PARITY_EN
  logic par_bit;

  always_ff @(posedge clk) begin
    if (rst)                      par_bit <= 1'b0;
    else if (state == PAR && en)  par_bit <= in;
  end

  // Even parity over data plus parity bit; updated only alongside q
  always_ff @(posedge clk) begin
    if (rst)                   parity_err <= 1'b0;
    else if (xfer && out_free) parity_err <= (^sr) ^ par_bit;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed bench for sipo_frame_ctrl with an expected-word scoreboard queue.
module tb_sipo_frame_ctrl;
  localparam int WIDTH = 4;
`ifdef SIPO_FRAME_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic             perr;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst, in, en, q_ready;
  logic [WIDTH-1:0] q;
  logic             q_valid, busy, overrun, parity_err;

  int   checks = 0;
  int   failures = 0;
  int   busy_cnt;
  exp_t exp_q[$];
  exp_t cur;

  sipo_frame_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in(in), .en(en), .q(q), .q_valid(q_valid),
    .q_ready(q_ready), .busy(busy), .overrun(overrun), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_perr(input logic [WIDTH-1:0] d, input logic p);
    return (PB != 0) ? ((^d) ^ p) : 1'b0;
  endfunction

  task automatic strobe(input logic b, input int gap);
    in = b;
    en = 1'b0;
    repeat (gap) begin
      tick();
      busy_cnt += busy;
    end
    en = 1'b1;
    tick();
    busy_cnt += busy;
    en = 1'b0;
  endtask

  // Returns with the last strobe edge taken, i.e. during the DONE cycle
  task automatic send_frame(input logic [WIDTH-1:0] d, input logic p, input int gap);
    busy_cnt = 0;
    strobe(1'b1, 0);
    for (int i = WIDTH - 1; i >= 0; i--) strobe(d[i], gap);
    if (PB != 0) strobe(p, gap);
    in = 1'b0;
  endtask

  task automatic deliver(input string tag, input logic [WIDTH-1:0] d, input logic p, input int gap);
    exp_q.push_back('{d: d, perr: exp_perr(d, p)});
    send_frame(d, p, gap);
    check({tag, "_qv_before_done"}, q_valid, 1'b0);
    check({tag, "_busy_cycles"}, busy_cnt, 1 + (WIDTH + PB) * (gap + 1));
    tick();
    cur = exp_q.pop_front();
    check({tag, "_q"}, q, cur.d);
    check({tag, "_qv"}, q_valid, 1'b1);
    check({tag, "_perr"}, parity_err, cur.perr);
    check({tag, "_overrun"}, overrun, 1'b0);
    check({tag, "_busy_after"}, busy, 1'b0);
  endtask

  task automatic consume(input string tag);
    q_ready = 1'b1;
    tick();
    q_ready = 1'b0;
    check({tag, "_consumed_qv"}, q_valid, 1'b0);
    check({tag, "_consumed_q"}, q, cur.d);
  endtask

  initial begin
    logic [WIDTH-1:0] rd;
    logic             rp;
    rst = 1'b1; in = 1'b0; en = 1'b0; q_ready = 1'b0;
    cur = '0;
    tick();
    tick();
    check("rst_q", q, 0);
    check("rst_qv", q_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_perr", parity_err, 1'b0);
    rst = 1'b0;

    // Reset in the middle of a frame after two data bits
    strobe(1'b1, 0);
    strobe(1'b1, 0);
    strobe(1'b0, 0);
    check("mid_busy_pre", busy, 1'b1);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    in  = 1'b0;
    check("midrst_busy", busy, 1'b0);
    check("midrst_qv", q_valid, 1'b0);
    check("midrst_q", q, 0);
    check("midrst_overrun", overrun, 1'b0);

    deliver("frameA", 4'b1011, 1'b1, 0);
    repeat (3) tick();
    check("hold_q", q, 4'b1011);
    check("hold_qv", q_valid, 1'b1);

    // Second word while occupied and not ready: dropped
    send_frame(4'b0110, 1'b0, 0);
    tick();
    check("ovr_pulse", overrun, 1'b1);
    check("ovr_q", q, 4'b1011);
    check("ovr_qv", q_valid, 1'b1);
    check("ovr_perr", parity_err, cur.perr);
    tick();
    check("ovr_pulse_end", overrun, 1'b0);

    // Same word with ready in the DONE cycle: replaced, no overrun
    exp_q.push_back('{d: 4'b0110, perr: exp_perr(4'b0110, 1'b0)});
    send_frame(4'b0110, 1'b0, 0);
    q_ready = 1'b1;
    tick();
    q_ready = 1'b0;
    cur = exp_q.pop_front();
    check("swap_q", q, cur.d);
    check("swap_qv", q_valid, 1'b1);
    check("swap_overrun", overrun, 1'b0);
    check("swap_perr", parity_err, cur.perr);
    consume("swap");

    // Line high without strobes must not start a frame
    in = 1'b1;
    repeat (3) tick();
    check("idle_no_strobe_busy", busy, 1'b0);
    in = 1'b0;

    deliver("gap2", 4'b0011, 1'b0, 2);
    consume("gap2");

    deliver("par_good", 4'b1011, 1'b1, 0);
    consume("par_good");
    deliver("par_bad", 4'b1011, 1'b0, 0);
    consume("par_bad");

    for (int k = 0; k < 4; k++) begin
      rd = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      rp = 1'($urandom_range(0, 1));
      deliver("rand", rd, rp, k % 2);
      consume("rand");
    end

    // Back-to-back frames, start bit in the cycle right after DONE
    exp_q.push_back('{d: 4'b1100, perr: exp_perr(4'b1100, 1'b1)});
    exp_q.push_back('{d: 4'b0101, perr: exp_perr(4'b0101, 1'b0)});
    send_frame(4'b1100, 1'b1, 0);
    q_ready = 1'b1;
    tick();
    cur = exp_q.pop_front();
    check("b2b_first_q", q, cur.d);
    send_frame(4'b0101, 1'b0, 0);
    check("b2b_busy_cycles", busy_cnt, WIDTH + PB + 1);
    tick();
    q_ready = 1'b0;
    cur = exp_q.pop_front();
    check("b2b_second_q", q, cur.d);
    check("b2b_second_qv", q_valid, 1'b1);
    check("b2b_second_perr", parity_err, cur.perr);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("final_rst_q", q, 0);
    check("final_rst_qv", q_valid, 1'b0);
    check("final_rst_perr", parity_err, 1'b0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sipo_frame_ctrl.md
Name: sipo_frame_ctrl

Overview:
- Framed serial-in/parallel-out receive controller built around the team's SIPO shift path.
- Detects a start bit on the serial line and counts WIDTH data bits into an internal shift register.
- Transfers the word to a held parallel output register with a valid/ready handshake to the downstream consumer.
- Flags overruns when a new word completes while the output register is still occupied.

Parameters:
- WIDTH, 4, number of data bits per frame and width of q. Legal range 2..32.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous reset, active-high.
- in  input  1  serial data line; idles low.
- en  input  1  bit strobe; `in` is sampled only on cycles with en=1.
- q  output  WIDTH  parallel word, registered.
- q_valid  output  1  q holds an unconsumed word.
- q_ready  input  1  consumer accepts q this cycle when q_valid=1.
- busy  output  1  high while a frame is in progress (state ≠ IDLE).
- overrun  output  1  one-cycle pulse: completed word dropped.
- parity_err  output  1  parity status of the word in q; see Optional Feature.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst). On rst=1 at a clock edge:
  - state=IDLE; bit counter=0; shift reg=0.
  - q=0, q_valid=0, busy=0, overrun=0, parity_err=0.
  - rst overrides every other input, including mid-frame; any partial frame is discarded.
- State machine:
  - IDLE: on en=1 and in=1 (start bit), go to SHIFT with cnt=0. en=0 or in=0: stay.
  - SHIFT: on en=1, sr <= {sr[WIDTH-2:0], in} (first data bit ends up as the MSB); cnt++. When cnt==WIDTH-1 with en=1, go to PAR (macro on) or DONE. en=0: hold sr, cnt and state.
  - PAR (macro only): on en=1, sample the parity bit, then go to DONE. en=0: hold.
  - DONE: one cycle, independent of en; performs the output transfer below, then goes to IDLE.
- Output transfer in DONE:
  - Load condition: the output register is free, i.e. q_valid=0, or q_valid=1 and q_ready=1 in the same cycle.
  - If free: q <= sr, q_valid <= 1, parity_err updated.
  - If not free: the word is dropped; q, q_valid and parity_err are unchanged; overrun=1 for exactly one cycle.
  - Consume (q_valid=1 and q_ready=1) outside DONE: q_valid <= 0; q retains its value.
  - q_ready is ignored while q_valid=0.
- Latency with en=1 continuously:
  - Start bit sampled at edge E0; data bits at E1..EWIDTH.
  - q_valid visible after edge E(WIDTH+1), or E(WIDTH+2) with the macro.
- busy=1 in SHIFT, PAR and DONE; 0 in IDLE.
- A start bit may be accepted in the cycle immediately after DONE; back-to-back frames have no gap.
- in is treated as synchronous to clk; no synchroniser is inside this block.

Optional Feature:
- Macro: SIPO_FRAME_PARITY_EN.
- Defined:
  - PAR state is present; one extra strobed bit follows the data bits.
  - Even parity: XOR of the data bits and the parity bit must be 0.
  - parity_err is loaded with the mismatch result together with q.
  - The word is delivered even when parity_err=1.
- Not defined:
  - No PAR state; frames are start bit + WIDTH data bits.
  - parity_err is tied to 0.
  - The port list is identical in both builds.

Test Plan:
- rst=1 for 2 cycles, including once mid-frame after 2 data bits → q=0, q_valid=0, busy=0, overrun=0. The next clean frame 1,1,0,1,1 decodes to q=4'b1011.
- en=1 continuously, q_ready=0, in=1,1,0,1,1 → q=4'b1011; q_valid rises 5 cycles after the start edge; busy high for 5 cycles; q_valid and q held until q_ready=1.
- Second frame 1,0,1,1,0 while q_valid=1 and q_ready=0 → single-cycle overrun pulse; q stays 4'b1011; q_valid stays 1.
- Same second frame with q_ready=1 in the DONE cycle → q=4'b0110; q_valid stays 1; no overrun.
- en asserted every third cycle with in held stable between strobes, frame 1,0,0,1,1 → q=4'b0011; no bits sampled when en=0.
- SIPO_FRAME_PARITY_EN defined, frame 1,1,0,1,1 then parity 1 → q=4'b1011, parity_err=0. Parity 0 instead → q=4'b1011, parity_err=1.
